// File: rtl/stdp_if.sv
// -----------------------------------------------------------------------------
// stdp_if
// Signal bundle between the STDP controller and its neighbours (neuron spikes,
// weight load port, weight/current outputs and the update report).
//
//   pre_spike     presynaptic LIF spike, single-cycle pulse
//   post_spike    postsynaptic LIF spike, single-cycle pulse
//   learn_en      1 = plasticity active, 0 = weight frozen
//   w_load        synchronous weight load strobe
//   w_load_val    value written on w_load (clamped to W_MAX)
//   weight        current synaptic weight
//   syn_current   weight if pre_spike was high last cycle, else 0
//   update_valid  one-cycle pulse when STDP changed the weight
//   update_ltp    1 = potentiation, 0 = depression (qualifies update_valid)
//   time_diff     |dt| of the last applied pair
//
// master: the side driving spikes/controls; slave: the controller.
// -----------------------------------------------------------------------------
interface stdp_if;
    logic       pre_spike;
    logic       post_spike;
    logic       learn_en;
    logic       w_load;
    logic [7:0] w_load_val;
    logic [7:0] weight;
    logic [7:0] syn_current;
    logic       update_valid;
    logic       update_ltp;
    logic [3:0] time_diff;

    modport master (
        output pre_spike, post_spike, learn_en, w_load, w_load_val,
        input  weight, syn_current, update_valid, update_ltp, time_diff
    );

    modport slave (
        input  pre_spike, post_spike, learn_en, w_load, w_load_val,
        output weight, syn_current, update_valid, update_ltp, time_diff
    );
endinterface

// File: rtl/stdp_ctrl.sv
// -----------------------------------------------------------------------------
// stdp_ctrl
// Spike-timing-dependent plasticity controller for a single synapse. Pairs a
// reference spike with the nearest partner spike inside a window of
// 4 << BIN_SHIFT cycles and applies a binned, shift-based weight change
// (DW_MAX >> bin). Also drives the postsynaptic input current.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    stdp_if.slave (spikes, learn_en, weight load, weight/current out,
//          update report)
//
// Build option:
//   STDP_LTD_EN  when defined, post-before-pre pairs depress the weight.
//                When undefined only pre-before-post potentiation exists and
//                a post spike with no open window is ignored.
// -----------------------------------------------------------------------------
module stdp_ctrl #(
    parameter logic [7:0] W_INIT    = 8'd1,
    parameter logic [7:0] W_MAX     = 8'd255,
    parameter logic [7:0] DW_MAX    = 8'd16,
    parameter int         BIN_SHIFT = 1
) (
    input logic   clk,
    input logic   rst_n,
    stdp_if.slave bus
);

    localparam int            WINDOW = 4 << BIN_SHIFT;
    localparam int            TW     = $clog2(WINDOW + 1);
    localparam logic [TW-1:0] WIN_T  = TW'(WINDOW);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_POST,
        WAIT_PRE,
        UPDATE
    } state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [TW-1:0] pend_dt, pend_dt_nxt;
    logic          pend_ltp, pend_ltp_nxt;
    logic          commit_p0;

    logic [7:0]    weight_p1;
    logic          vld_p1;
    logic          ltp_p1;
    logic [3:0]    dt_p1;
    logic          pre_p1;

    // delta = DW_MAX >> ((k-1) >> BIN_SHIFT)
    function automatic logic [7:0] delta_of(input logic [TW-1:0] k);
        logic [TW-1:0] bin;
        bin = (k - TW'(1)) >> BIN_SHIFT;
        return DW_MAX >> bin;
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] w, input logic [7:0] d);
        logic [8:0] s;
        s = {1'b0, w} + {1'b0, d};
        if (s > {1'b0, W_MAX}) return W_MAX;
        return s[7:0];
    endfunction

    function automatic logic [7:0] sat_sub(input logic [7:0] w, input logic [7:0] d);
        logic signed [8:0] s;
        s = $signed({1'b0, w}) - $signed({1'b0, d});
        if (s < 9'sd0) return 8'd0;
        return s[7:0];
    endfunction

    function automatic logic [7:0] clamp_load(input logic [7:0] v);
        return (v > W_MAX) ? W_MAX : v;
    endfunction

    // ---- stage p0: pairing FSM ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            timer    <= '0;
            pend_dt  <= '0;
            pend_ltp <= 1'b0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            pend_dt  <= pend_dt_nxt;
            pend_ltp <= pend_ltp_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        timer_nxt    = timer;
        pend_dt_nxt  = pend_dt;
        pend_ltp_nxt = pend_ltp;
        case (state)
            // The UPDATE cycle evaluates new spikes exactly like IDLE, so a
            // spike there can open a fresh window; the consumed partner cannot.
            IDLE, UPDATE: begin
                state_nxt = IDLE;
                timer_nxt = '0;
                if (bus.pre_spike && !bus.post_spike) begin
                    state_nxt = WAIT_POST;
                    timer_nxt = TW'(1);
                end
`ifdef STDP_LTD_EN
                else if (bus.post_spike && !bus.pre_spike) begin
                    state_nxt = WAIT_PRE;
                    timer_nxt = TW'(1);
                end
`endif
            end
            WAIT_POST: begin
                // timer equals dt of the current cycle; the pairing spike wins
                // over a same-cycle reference spike.
                if (bus.post_spike) begin
                    state_nxt    = UPDATE;
                    timer_nxt    = '0;
                    pend_dt_nxt  = timer;
                    pend_ltp_nxt = 1'b1;
                end else if (bus.pre_spike) begin
                    timer_nxt = TW'(1);
                end else if (timer >= WIN_T) begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
`ifdef STDP_LTD_EN
            WAIT_PRE: begin
                if (bus.pre_spike) begin
                    state_nxt    = UPDATE;
                    timer_nxt    = '0;
                    pend_dt_nxt  = timer;
                    pend_ltp_nxt = 1'b0;
                end else if (bus.post_spike) begin
                    timer_nxt = TW'(1);
                end else if (timer >= WIN_T) begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
            end
        endcase
        if (!bus.learn_en || bus.w_load) begin
            state_nxt = IDLE;
            timer_nxt = '0;
        end
    end

    // A load or learn_en=0 in the UPDATE cycle suppresses the commit.
    assign commit_p0 = (state == UPDATE) && bus.learn_en && !bus.w_load;

    // ---- stage p1: weight commit and update report ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weight_p1 <= W_INIT;
            vld_p1    <= 1'b0;
            ltp_p1    <= 1'b0;
            dt_p1     <= 4'd0;
            pre_p1    <= 1'b0;
        end else begin
            vld_p1 <= commit_p0;
            pre_p1 <= bus.pre_spike;
            if (bus.w_load) begin
                weight_p1 <= clamp_load(bus.w_load_val);
            end else if (commit_p0) begin
                weight_p1 <= pend_ltp ? sat_add(weight_p1, delta_of(pend_dt))
                                      : sat_sub(weight_p1, delta_of(pend_dt));
                ltp_p1    <= pend_ltp;
                dt_p1     <= 4'(pend_dt);
            end
        end
    end

    assign bus.weight       = weight_p1;
    assign bus.syn_current  = pre_p1 ? weight_p1 : 8'd0;
    assign bus.update_valid = vld_p1;
    assign bus.update_ltp   = ltp_p1;
    assign bus.time_diff    = dt_p1;

endmodule

// File: tb/tb_stdp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stdp_ctrl
// Self-checking bench for stdp_ctrl: a hand-written cycle table, a few
// multi-cycle corner sequences, and a randomized run against a time-stamp
// based reference model. Honours STDP_LTD_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_stdp_ctrl;

    localparam int W_INIT    = 1;
    localparam int W_MAX     = 255;
    localparam int DW_MAX    = 16;
    localparam int BIN_SHIFT = 1;
    localparam int WIN       = 4 << BIN_SHIFT;
`ifdef STDP_LTD_EN
    localparam bit LTD = 1'b1;
`else
    localparam bit LTD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    stdp_if bus();

    stdp_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (time-stamp based) ----------------
    int m_t, m_ref_t, m_pend_k, m_w, m_td;
    bit m_ref_valid, m_ref_pre, m_pend, m_pend_ltp, m_uv, m_ltp, m_pre_d;

    task automatic model_reset();
        m_t = 0; m_ref_t = 0; m_pend_k = 0; m_w = W_INIT; m_td = 0;
        m_ref_valid = 0; m_ref_pre = 0; m_pend = 0; m_pend_ltp = 0;
        m_uv = 0; m_ltp = 0; m_pre_d = 0;
    endtask

    // Advances the model by one clock edge with the inputs of this cycle.
    task automatic model_step(input bit pre, input bit post, input bit learn,
                              input bit wl, input int wlv);
        bit commit_now, next_pend, next_ltp, partner, same;
        int k, next_k, delta;
        commit_now = m_pend;
        next_pend  = 0;
        next_ltp   = 0;
        next_k     = 0;
        m_uv       = 0;
        if (wl) begin
            m_w = (wlv > W_MAX) ? W_MAX : wlv;
        end else if (commit_now && learn) begin
            delta = DW_MAX >> ((m_pend_k - 1) >> BIN_SHIFT);
            if (m_pend_ltp) m_w = (m_w + delta > W_MAX) ? W_MAX : m_w + delta;
            else            m_w = (m_w - delta < 0) ? 0 : m_w - delta;
            m_uv  = 1;
            m_ltp = m_pend_ltp;
            m_td  = m_pend_k;
        end
        k = m_t - m_ref_t;
        if (!commit_now && m_ref_valid && k <= WIN) begin
            partner = m_ref_pre ? post : pre;
            same    = m_ref_pre ? pre : post;
            if (partner) begin
                next_pend   = 1;
                next_k      = k;
                next_ltp    = m_ref_pre;
                m_ref_valid = 0;
            end else if (same) begin
                m_ref_t = m_t;
            end
        end else begin
            m_ref_valid = 0;
            if (pre && !post) begin
                m_ref_valid = 1; m_ref_pre = 1; m_ref_t = m_t;
            end else if (post && !pre && LTD) begin
                m_ref_valid = 1; m_ref_pre = 0; m_ref_t = m_t;
            end
        end
        if (!learn || wl) begin
            m_ref_valid = 0;
            next_pend   = 0;
        end
        m_pend     = next_pend;
        m_pend_k   = next_k;
        m_pend_ltp = next_ltp;
        m_pre_d    = pre;
        m_t++;
    endtask

    // ---------------- helpers ----------------
    task automatic do_reset();
        rst_n = 1'b0;
        bus.pre_spike = 0; bus.post_spike = 0; bus.learn_en = 1;
        bus.w_load = 0; bus.w_load_val = 8'd0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic step(input bit pre, input bit post);
        bus.pre_spike  = pre;
        bus.post_spike = post;
        @(negedge clk);
    endtask

    typedef struct {
        bit         pre;
        bit         post;
        bit         wl;
        logic [7:0] wlv;
        int         ew;
        bit         euv;
        bit         eltp;
        int         etd;
        int         esyn;
    } vec_t;

    vec_t vq[$];

    task automatic add(input bit pre, input bit post, input bit wl, input int wlv,
                       input int ew, input bit euv, input bit eltp, input int etd,
                       input int esyn);
        vec_t v;
        v.pre = pre; v.post = post; v.wl = wl; v.wlv = 8'(wlv);
        v.ew = ew; v.euv = euv; v.eltp = eltp; v.etd = etd; v.esyn = esyn;
        vq.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int w1, ltp1, td1, w2, ltp2, w3;
        bit pre, post, learn, wl;
        int wlv;

        // ---------------- table ----------------
        w1   = LTD ? 13 : 17;
        ltp1 = LTD ? 0 : 1;
        td1  = LTD ? 5 : 1;
        w2   = LTD ? 0 : 3;
        ltp2 = LTD ? 0 : 1;
        w3   = w2 + 16;
        // each row: inputs applied this cycle, expected outputs seen this cycle
        add(0,0,0,0,   1,0,0,0,0);
        add(1,0,0,0,   1,0,0,0,0);      // pre
        add(0,1,0,0,   1,0,0,0,1);      // post, k=1
        add(0,0,0,0,   1,0,0,0,0);      // UPDATE
        add(0,0,0,0,  17,1,1,1,0);
        add(0,0,0,0,  17,0,1,1,0);
        add(0,1,0,0,  17,0,1,1,0);      // post reference
        for (int i = 0; i < 4; i++) add(0,0,0,0, 17,0,1,1,0);
        add(1,0,0,0,  17,0,1,1,0);      // pre, k=5
        add(0,0,0,0,  17,0,1,1,17);
        add(0,0,0,0,  w1,LTD,ltp1,td1,0);
        add(1,0,0,0,  w1,0,ltp1,td1,0); // pre with no partner
        add(0,0,0,0,  w1,0,ltp1,td1,w1);
        for (int i = 0; i < 9; i++) add(0,0,0,0, w1,0,ltp1,td1,0);
        add(1,1,0,0,  w1,0,ltp1,td1,0); // same-cycle pair
        add(0,0,0,0,  w1,0,ltp1,td1,w1);
        add(0,0,0,0,  w1,0,ltp1,td1,0);
        add(0,0,0,0,  w1,0,ltp1,td1,0);
        add(0,0,1,250, w1,0,ltp1,td1,0);
        add(1,0,0,0,  250,0,ltp1,td1,0);
        add(0,1,0,0,  250,0,ltp1,td1,250);
        add(0,0,0,0,  250,0,ltp1,td1,0);
        add(0,0,0,0,  255,1,1,1,0);     // saturated, still pulses
        add(0,0,0,0,  255,0,1,1,0);
        add(0,0,1,3,  255,0,1,1,0);
        add(0,1,0,0,  3,0,1,1,0);
        add(1,0,0,0,  3,0,1,1,0);       // LTD k=1
        add(0,0,0,0,  3,0,1,1,3);
        add(0,0,0,0,  w2,LTD,ltp2,1,0);
        add(1,0,0,0,  w2,0,ltp2,1,0);   // first pre
        add(0,0,0,0,  w2,0,ltp2,1,w2);
        add(0,0,0,0,  w2,0,ltp2,1,0);
        add(0,0,0,0,  w2,0,ltp2,1,0);
        add(1,0,0,0,  w2,0,ltp2,1,0);   // nearer pre
        add(0,0,0,0,  w2,0,ltp2,1,w2);
        add(0,1,0,0,  w2,0,ltp2,1,0);   // post, dt=2 from nearer pre
        add(0,0,0,0,  w2,0,ltp2,1,0);
        add(0,0,0,0,  w3,1,1,2,0);
        add(0,0,0,0,  w3,0,1,2,0);

        do_reset();
        check("reset_weight", bus.weight, W_INIT);
        check("reset_syn", bus.syn_current, 0);
        check("reset_valid", bus.update_valid, 0);
        check("reset_ltp", bus.update_ltp, 0);
        check("reset_tdiff", bus.time_diff, 0);

        foreach (vq[i]) begin
            check($sformatf("tbl%0d_weight", i), bus.weight, vq[i].ew);
            check($sformatf("tbl%0d_valid", i), bus.update_valid, vq[i].euv);
            check($sformatf("tbl%0d_ltp", i), bus.update_ltp, vq[i].eltp);
            check($sformatf("tbl%0d_tdiff", i), bus.time_diff, vq[i].etd);
            check($sformatf("tbl%0d_syn", i), bus.syn_current, vq[i].esyn);
            bus.pre_spike  = vq[i].pre;
            bus.post_spike = vq[i].post;
            bus.w_load     = vq[i].wl;
            bus.w_load_val = vq[i].wlv;
            @(negedge clk);
        end
        bus.w_load = 0;

        // ---------------- window edge: k=8 pairs, delta 2 ----------------
        do_reset();
        step(1,0);
        for (int i = 0; i < 7; i++) step(0,0);
        step(0,1);
        step(0,0);
        check("k8_weight", bus.weight, 3);
        check("k8_valid", bus.update_valid, 1);
        check("k8_tdiff", bus.time_diff, 8);
        check("k8_ltp", bus.update_ltp, 1);
        step(0,0);
        check("k8_valid_drop", bus.update_valid, 0);

        // ---------------- k=9 is outside the window ----------------
        do_reset();
        step(1,0);
        for (int i = 0; i < 8; i++) step(0,0);
        step(0,1);
        step(0,0);
        check("k9_valid", bus.update_valid, 0);
        check("k9_weight", bus.weight, W_INIT);
        step(0,0);
        check("k9_valid_late", bus.update_valid, 0);

        // ---------------- asynchronous reset mid-window ----------------
        do_reset();
        bus.w_load = 1; bus.w_load_val = 8'd100;
        step(0,0);
        bus.w_load = 0;
        check("rst_preload", bus.weight, 100);
        step(1,0);
        step(0,0);
        rst_n = 1'b0;
        #1;
        check("rst_async_weight", bus.weight, W_INIT);
        @(negedge clk);
        rst_n = 1'b1;
        step(0,1);
        for (int i = 0; i < 3; i++) begin
            step(0,0);
            check("rst_no_valid", bus.update_valid, 0);
            check("rst_weight", bus.weight, W_INIT);
        end

        // ---------------- learn_en=0 during a pair ----------------
        do_reset();
        step(1,0);
        bus.learn_en = 0;
        step(0,1);
        bus.learn_en = 1;
        for (int i = 0; i < 3; i++) begin
            step(0,0);
            check("frz_no_valid", bus.update_valid, 0);
            check("frz_weight", bus.weight, W_INIT);
        end

        // ---------------- w_load beats a same-cycle commit ----------------
        do_reset();
        step(1,0);
        step(0,1);
        bus.w_load = 1; bus.w_load_val = 8'd100;
        step(0,0);
        bus.w_load = 0;
        check("wl_prio_weight", bus.weight, 100);
        check("wl_prio_valid", bus.update_valid, 0);
        step(0,0);
        check("wl_prio_valid2", bus.update_valid, 0);
        check("wl_prio_weight2", bus.weight, 100);

        // ---------------- randomized run against the model ----------------
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            check("rnd_weight", bus.weight, m_w);
            check("rnd_valid", bus.update_valid, m_uv);
            check("rnd_syn", bus.syn_current, m_pre_d ? m_w : 0);
            if (m_uv) begin
                check("rnd_ltp", bus.update_ltp, m_ltp);
                check("rnd_tdiff", bus.time_diff, m_td);
            end
            pre   = ($urandom % 5) == 0;
            post  = ($urandom % 5) == 0;
            learn = ($urandom % 40) != 0;
            wl    = ($urandom % 100) == 0;
            wlv   = $urandom_range(0, 255);
            bus.pre_spike  = pre;
            bus.post_spike = post;
            bus.learn_en   = learn;
            bus.w_load     = wl;
            bus.w_load_val = 8'(wlv);
            model_step(pre, post, learn, wl, wlv);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
